// File: rtl/lampFPU_pkg.sv
// rtl/lampFPU_pkg.sv - shared widths, state encoding, constants and seed helper for the Goldschmidt sqrt core
package lampFPU_pkg;

    localparam int F_DW_DEF      = 7;
    localparam int PREC_DW_DEF   = 8;
    localparam int APPROX_DW_DEF = 4;
    localparam int ITER_MAX_DEF  = 6;

    // Internal word is Q2.(F_DW+PREC_DW); iteration fields count 0..ITER_MAX
    localparam int GS_W   = 2 + F_DW_DEF + PREC_DW_DEF;
    localparam int GS_ITW = $clog2(ITER_MAX_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_B,
        COMPL,
        MUL_R,
        DONE
    } gs_state_e;

    // Integer parts of 1.0 and 3.0 in the Q2 word; the fraction is appended as zeros
    localparam logic [1:0] ONE_Q   = 2'd1;
    localparam logic [1:0] THREE_Q = 2'd3;

    // floor(2^A / sqrt(idx / 2^(A-1))) computed as isqrt(floor(2^(3A-1) / idx));
    // indices below 0.5 are never valid operands and map to 0
    function automatic int gs_seed(input int approx_dw, input int idx);
        int x;
        int r;
        if (idx < (1 << (approx_dw - 2))) begin
            return 0;
        end
        x = (1 << (3 * approx_dw - 1)) / idx;
        r = 0;
        for (int k = 0; k < (1 << (approx_dw + 1)); k++) begin
            if ((r + 1) * (r + 1) <= x) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lamp_fpu_gs_sqrt_seed.sv
// rtl/lamp_fpu_gs_sqrt_seed.sv - combinational 1/sqrt seed table, Q1.APPROX_DW entries
module lamp_fpu_gs_sqrt_seed
    import lampFPU_pkg::*;
#(
    parameter int APPROX_DW = APPROX_DW_DEF
) (
    input  logic [APPROX_DW-1:0] idx,
    output logic [APPROX_DW:0]   seed
);

    localparam int SW = APPROX_DW + 1;

    logic [SW-1:0] lut [2**APPROX_DW];

    for (genvar i = 0; i < 2**APPROX_DW; i++) begin : g_lut
        localparam logic [SW-1:0] SEED_VAL = SW'(gs_seed(APPROX_DW, i));
        assign lut[i] = SEED_VAL;
    end

    assign seed = lut[idx];

endmodule

// File: rtl/lamp_fpu_gs_sqrt.sv
// rtl/lamp_fpu_gs_sqrt.sv - iterative Goldschmidt sqrt / inverse sqrt core; option LAMP_GS_EARLY_TERM_EN
module lamp_fpu_gs_sqrt
    import lampFPU_pkg::*;
#(
    parameter int F_DW      = F_DW_DEF,
    parameter int PREC_DW   = PREC_DW_DEF,
    parameter int APPROX_DW = APPROX_DW_DEF,
    parameter int ITER_MAX  = ITER_MAX_DEF,
    parameter int ITW       = $clog2(ITER_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [F_DW:0]   s_i,
    input  logic            mode_i,
    input  logic [ITW-1:0]  iters_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [F_DW+1:0] result_o,
    output logic            sticky_o,
    output logic            invalid_o,
    output logic [ITW-1:0]  iter_o
);

    localparam int FB = F_DW + PREC_DW;
    localparam int W  = 2 + FB;
    localparam int W2 = 2 * W;
    localparam int RW = F_DW + 2;
    localparam int SW = APPROX_DW + 1;

    localparam logic [W-1:0] THREE_W = {THREE_Q, {FB{1'b0}}};
`ifdef LAMP_GS_EARLY_TERM_EN
    localparam logic [W-1:0] ONE_W = {ONE_Q, {FB{1'b0}}};
`endif

    gs_state_e      state;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    logic [W-1:0]   y;
    logic [ITW-1:0] cnt;
    logic [ITW-1:0] n_q;
    logic           mode_q;

    logic           accept;
    logic           bad_in;
    logic [ITW-1:0] iters_clamp;
    logic [SW-1:0]  seed;
    logic [W-1:0]   b_init;
    logic [W-1:0]   r_init;
    logic [W-1:0]   b_r;
    logic [W-1:0]   b_next;
    logic [W-1:0]   r_next;
    logic [W-1:0]   y_mul;
    logic [W-1:0]   y_next;
    logic [RW-1:0]  res_next;
    logic           stk_next;
    logic [ITW-1:0] cnt_inc;

    assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign bad_in      = (s_i[F_DW -: 2] == 2'b00);
    assign iters_clamp = (iters_i > ITW'(ITER_MAX)) ? ITW'(ITER_MAX) : iters_i;

    lamp_fpu_gs_sqrt_seed #(
        .APPROX_DW (APPROX_DW)
    ) u_seed (
        .idx  (s_i[F_DW -: APPROX_DW]),
        .seed (seed)
    );

    // Operand and seed aligned into the Q2.FB working format
    assign b_init = {1'b0, s_i, {PREC_DW{1'b0}}};
    assign r_init = {1'b0, seed, {(FB - APPROX_DW){1'b0}}};

    // Truncating datapath; b*r doubles as the SEED-state sqrt product since b still holds s there
    assign b_r      = W'((W2'(b) * W2'(r)) >> FB);
    assign b_next   = W'((W2'(b_r) * W2'(r)) >> FB);
    assign r_next   = (THREE_W - b) >> 1;
    assign y_mul    = W'((W2'(y) * W2'(r)) >> FB);
    assign y_next   = (state == SEED)  ? (mode_q ? r : b_r) :
                      (state == MUL_R) ? y_mul : y;
    assign res_next = RW'(y_next >> (PREC_DW - 1));
    assign stk_next = |y_next[PREC_DW-2:0];
    assign cnt_inc  = cnt + ITW'(1);

    // Control FSM with datapath registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            b           <= '0;
            r           <= '0;
            y           <= '0;
            cnt         <= '0;
            n_q         <= '0;
            mode_q      <= 1'b0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            sticky_o    <= 1'b0;
            invalid_o   <= 1'b0;
            iter_o      <= '0;
        end else if (accept) begin
            b      <= b_init;
            r      <= r_init;
            cnt    <= '0;
            n_q    <= iters_clamp;
            mode_q <= mode_i;
            if (bad_in) begin
                state       <= DONE;
                out_valid_o <= 1'b1;
                result_o    <= '0;
                sticky_o    <= 1'b0;
                invalid_o   <= 1'b1;
                iter_o      <= '0;
            end else begin
                state       <= SEED;
                out_valid_o <= 1'b0;
                invalid_o   <= 1'b0;
            end
        end else begin
            case (state)
                SEED: begin
                    y <= y_next;
                    if (n_q == '0) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                        result_o    <= res_next;
                        sticky_o    <= stk_next;
                        iter_o      <= '0;
                    end else begin
                        state <= MUL_B;
                    end
                end
                MUL_B: begin
                    b     <= b_next;
                    state <= COMPL;
                end
                COMPL: begin
                    r <= r_next;
`ifdef LAMP_GS_EARLY_TERM_EN
                    if (r_next == ONE_W) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                        result_o    <= res_next;
                        sticky_o    <= stk_next;
                        iter_o      <= cnt_inc;
                    end else begin
                        state <= MUL_R;
                    end
`else
                    state <= MUL_R;
`endif
                end
                MUL_R: begin
                    y   <= y_next;
                    cnt <= cnt_inc;
                    if (cnt_inc == n_q) begin
                        state       <= DONE;
                        out_valid_o <= 1'b1;
                        result_o    <= res_next;
                        sticky_o    <= stk_next;
                        iter_o      <= cnt_inc;
                    end else begin
                        state <= MUL_B;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_fpu_gs_sqrt.sv
// tb/tb_lamp_fpu_gs_sqrt.sv - self-checking bench for lamp_fpu_gs_sqrt with a scoreboard queue
module tb_lamp_fpu_gs_sqrt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [7:0] s_i;
    logic       mode_i;
    logic [2:0] iters_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [8:0] result_o;
    logic       sticky_o;
    logic       invalid_o;
    logic [2:0] iter_o;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int res;
        int tol;
        bit chk_stk;
        bit stk;
        bit inv;
        int itr;
        int lat;
    } exp_t;

    typedef struct packed {
        logic [7:0] s;
        logic       m;
        logic [2:0] it;
    } stim_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lamp_fpu_gs_sqrt #(
        .F_DW      (7),
        .PREC_DW   (8),
        .APPROX_DW (4),
        .ITER_MAX  (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .s_i         (s_i),
        .mode_i      (mode_i),
        .iters_i     (iters_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .sticky_o    (sticky_o),
        .invalid_o   (invalid_o),
        .iter_o      (iter_o)
    );

    // Reference: exact real-valued sqrt / rsqrt, or the exact seed-only product for zero iterations
    function automatic exp_t model(input logic [7:0] s, input logic m, input int it);
        exp_t e;
        real  sv;
        real  y;
        real  seed;
        int   n;
        n = (it > 6) ? 6 : it;
        sv = $itor(s) / 128.0;
        e.chk_stk = 1'b0;
        e.stk = 1'b0;
        e.tol = 0;
        e.inv = 1'b0;
        e.itr = n;
        e.lat = 2 + 3 * n;
        if (s[7:6] == 2'b00) begin
            e.res = 0;
            e.chk_stk = 1'b1;
            e.inv = 1'b1;
            e.itr = 0;
            e.lat = 1;
        end else if (n == 0) begin
            seed = $floor(16.0 / $sqrt($itor(s[7:4]) / 8.0));
            y = m ? seed / 16.0 : sv * seed / 16.0;
            e.res = $rtoi($floor(y * 256.0));
            e.chk_stk = 1'b1;
            e.stk = (y * 256.0 != $itor(e.res));
        end else begin
            y = m ? 1.0 / $sqrt(sv) : $sqrt(sv);
            e.res = $rtoi($floor(y * 256.0));
            e.tol = (s == 8'h80) ? 0 : 1;
            e.chk_stk = (s == 8'h80);
        end
        return e;
    endfunction

    task automatic issue(input logic [7:0] s, input logic m, input int it);
        bit got;
        s_i = s;
        mode_i = m;
        iters_i = 3'(it);
        in_valid_i = 1'b1;
        sb.push_back(model(s, m, it));
        got = in_ready_o;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = in_ready_o;
        end
        if (!got) begin
            total++;
            $display("FAIL accept_timeout s=%h: in_ready_o got 0 want 1", s);
        end
        @(posedge clk);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic collect(output logic [8:0] r, output logic st, output logic inv,
                           output logic [2:0] itr, output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid_o) begin
                lat = k;
                break;
            end
        end
        r = result_o;
        st = sticky_o;
        inv = invalid_o;
        itr = iter_o;
        if (lat < 0) begin
            total++;
            $display("FAIL collect_timeout: out_valid_o got 0 want 1 within 100 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        s_i = '0;
        mode_i = 1'b0;
        iters_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (out_valid_o !== 1'b0) $display("FAIL reset out_valid_o: got %b want 0", out_valid_o); else passed++;
        total++; if (result_o !== 9'h000) $display("FAIL reset result_o: got %h want 000", result_o); else passed++;
        total++; if (sticky_o !== 1'b0) $display("FAIL reset sticky_o: got %b want 0", sticky_o); else passed++;
        total++; if (invalid_o !== 1'b0) $display("FAIL reset invalid_o: got %b want 0", invalid_o); else passed++;
        total++; if (iter_o !== 3'd0) $display("FAIL reset iter_o: got %0d want 0", iter_o); else passed++;
        total++; if (in_ready_o !== 1'b1) $display("FAIL reset in_ready_o: got %b want 1", in_ready_o); else passed++;
    endtask

    task automatic test_convergence();
        stim_t tbl[10] = '{
            '{8'h80, 1'b0, 3'd4}, '{8'h80, 1'b1, 3'd4}, '{8'h40, 1'b0, 3'd4}, '{8'h40, 1'b1, 3'd4},
            '{8'hFF, 1'b0, 3'd4}, '{8'hFF, 1'b1, 3'd4}, '{8'h4F, 1'b0, 3'd4}, '{8'hA3, 1'b1, 3'd3},
            '{8'h5A, 1'b0, 3'd6}, '{8'hC0, 1'b1, 3'd5}
        };
        logic [8:0] r;
        logic       st;
        logic       inv;
        logic [2:0] itr;
        int         lat;
        int         d;
        exp_t       e;
        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].s, tbl[i].m, int'(tbl[i].it));
            collect(r, st, inv, itr, lat);
            e = sb.pop_front();
            d = int'(r) - e.res;
            total++; if (d > e.tol || d < -e.tol) $display("FAIL conv s=%h m=%0d result_o: got %h want %h +/-%0d", tbl[i].s, tbl[i].m, r, e.res, e.tol); else passed++;
            total++; if (inv !== e.inv) $display("FAIL conv s=%h invalid_o: got %b want %b", tbl[i].s, inv, e.inv); else passed++;
            total++; if (int'(itr) !== e.itr) $display("FAIL conv s=%h iter_o: got %0d want %0d", tbl[i].s, itr, e.itr); else passed++;
            total++; if (lat !== e.lat) $display("FAIL conv s=%h latency: got %0d want %0d", tbl[i].s, lat, e.lat); else passed++;
            if (e.chk_stk) begin
                total++; if (st !== e.stk) $display("FAIL conv s=%h sticky_o: got %b want %b", tbl[i].s, st, e.stk); else passed++;
            end
        end
    endtask

    task automatic test_invalid_and_iters();
        stim_t tbl[6] = '{
            '{8'h3F, 1'b0, 3'd4}, '{8'h00, 1'b1, 3'd2}, '{8'hC0, 1'b0, 3'd0},
            '{8'hC0, 1'b1, 3'd0}, '{8'h4F, 1'b0, 3'd0}, '{8'hFF, 1'b0, 3'd7}
        };
        logic [8:0] r;
        logic       st;
        logic       inv;
        logic [2:0] itr;
        int         lat;
        int         d;
        exp_t       e;
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].s, tbl[i].m, int'(tbl[i].it));
            collect(r, st, inv, itr, lat);
            e = sb.pop_front();
            d = int'(r) - e.res;
            total++; if (d > e.tol || d < -e.tol) $display("FAIL edge s=%h it=%0d result_o: got %h want %h +/-%0d", tbl[i].s, tbl[i].it, r, e.res, e.tol); else passed++;
            total++; if (inv !== e.inv) $display("FAIL edge s=%h invalid_o: got %b want %b", tbl[i].s, inv, e.inv); else passed++;
            total++; if (int'(itr) !== e.itr) $display("FAIL edge s=%h it=%0d iter_o: got %0d want %0d", tbl[i].s, tbl[i].it, itr, e.itr); else passed++;
            total++; if (lat !== e.lat) $display("FAIL edge s=%h it=%0d latency: got %0d want %0d", tbl[i].s, tbl[i].it, lat, e.lat); else passed++;
            if (e.chk_stk) begin
                total++; if (st !== e.stk) $display("FAIL edge s=%h sticky_o: got %b want %b", tbl[i].s, st, e.stk); else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] r;
        logic       st;
        logic       inv;
        logic [2:0] itr;
        int         lat;
        int         d;
        exp_t       e;
        issue(8'h40, 1'b0, 4);
        // Hold the result back and present a competing request with different operands
        out_ready_i = 1'b0;
        s_i = 8'hFF;
        mode_i = 1'b1;
        iters_i = 3'd2;
        in_valid_i = 1'b1;
        collect(r, st, inv, itr, lat);
        e = sb.pop_front();
        d = int'(r) - e.res;
        total++; if (d > e.tol || d < -e.tol) $display("FAIL bp first result_o: got %h want %h +/-%0d", r, e.res, e.tol); else passed++;
        total++; if (lat !== e.lat) $display("FAIL bp first latency: got %0d want %0d", lat, e.lat); else passed++;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid_o !== 1'b1 || result_o !== r || sticky_o !== st || iter_o !== itr || in_ready_o !== 1'b0)
                $display("FAIL bp hold cycle %0d: valid=%b res=%h stk=%b it=%0d rdy=%b want 1 %h %b %0d 0",
                         k, out_valid_o, result_o, sticky_o, iter_o, in_ready_o, r, st, itr);
            else passed++;
        end
        @(posedge clk);
        #1 out_ready_i = 1'b1;
        sb.push_back(model(8'hFF, 1'b1, 2));
        @(negedge clk);
        total++; if (in_ready_o !== 1'b1) $display("FAIL bp release in_ready_o: got %b want 1", in_ready_o); else passed++;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        collect(r, st, inv, itr, lat);
        e = sb.pop_front();
        d = int'(r) - e.res;
        total++; if (d > e.tol || d < -e.tol) $display("FAIL bp second result_o: got %h want %h +/-%0d", r, e.res, e.tol); else passed++;
        total++; if (lat !== e.lat) $display("FAIL bp second latency: got %0d want %0d", lat, e.lat); else passed++;
        total++; if (int'(itr) !== e.itr) $display("FAIL bp second iter_o: got %0d want %0d", itr, e.itr); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [8:0] r;
        logic       st;
        logic       inv;
        logic [2:0] itr;
        int         lat;
        int         d;
        int         spurious;
        exp_t       e;
        issue(8'hC0, 1'b0, 4);
        @(posedge clk);
        #2;
        in_valid_i = 1'b1;
        s_i = 8'h80;
        #1;
        total++; if (in_ready_o !== 1'b0) $display("FAIL busy in_ready_o: got %b want 0", in_ready_o); else passed++;
        in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0) $display("FAIL rst_mid out_valid_o: got %b want 0", out_valid_o); else passed++;
        sb.delete(sb.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready_o !== 1'b1) $display("FAIL rst_mid in_ready_o: got %b want 1", in_ready_o); else passed++;
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_o) spurious++;
        end
        total++; if (spurious !== 0) $display("FAIL rst_mid aborted op: out_valid_o high %0d cycles want 0", spurious); else passed++;
        issue(8'hFF, 1'b0, 4);
        collect(r, st, inv, itr, lat);
        e = sb.pop_front();
        d = int'(r) - e.res;
        total++; if (d > e.tol || d < -e.tol) $display("FAIL rst_mid next result_o: got %h want %h +/-%0d", r, e.res, e.tol); else passed++;
        total++; if (lat !== e.lat) $display("FAIL rst_mid next latency: got %0d want %0d", lat, e.lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_convergence();
        test_invalid_and_iters();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
